// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter.
// Captures a DIGITS-digit BCD word on start and folds one digit per clock,
// most-significant digit first, into acc = acc*10 + digit.
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN. When defined, digits above 9
// raise err and force bin_out to 0. When undefined, err is tied low and
// digits 10..15 are accumulated as raw values.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  // The index only has to count 0..DIGITS-1. Keep it at least one bit wide.
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [4*DIGITS-1:0]    shift_reg;
  logic [BIN_W-1:0]       acc_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [3:0]             digit;
  logic [BIN_W-1:0]       acc_next;

  // The current most-significant digit sits at the top of the shift register.
  assign digit = shift_reg[4*DIGITS-1 -: 4];

  // Multiply by ten as (acc<<3)+(acc<<1). The sum wraps modulo 2^BIN_W.
  assign acc_next = (acc_reg << 3) + (acc_reg << 1) + BIN_W'(digit);

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic digit_bad;
  logic err_latch_reg;

  assign digit_bad = (digit > 4'd9);
`else
  assign err = 1'b0;
`endif

  // Conversion FSM with registered outputs. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bin_out   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err           <= 1'b0;
      err_latch_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_reg <= bcd_in;
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= CONV;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_latch_reg <= 1'b0;
`endif
          end
        end

        CONV: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_reg << 4;
          idx_reg   <= idx_reg + 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_latch_reg <= err_latch_reg | digit_bad;
`endif
          if (idx_reg == LAST_IDX) begin
            // This is the last digit. Publish the result on the same edge.
            idx_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (err_latch_reg | digit_bad) begin
              bin_out <= '0;
              err     <= 1'b1;
            end else begin
              bin_out <= acc_next;
              err     <= 1'b0;
            end
`else
            bin_out <= acc_next;
`endif
          end
        end

        DONE: begin
          // The done pulse lasts exactly one cycle. A start seen here is dropped.
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq
// (DIGITS=4, BIN_W=14). Expected values are hand-computed constants.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk;
  logic              rst;
  logic              start;
  logic [15:0]       bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int tests_run;
  int tests_failed;
  int done_count;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it, and report a mismatch in one line.
  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  // Advance past one rising edge. Outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: start at edge k, optionally switch bcd_in after the
  // latch, check busy/done over k..k+5, the result at k+4, and that the old
  // bin_out is held while busy.
  task automatic convert(input string tag, input logic [15:0] bcd, input logic [15:0] alt,
                         input int exp_bin, input int exp_err, input int prev_bin);
    bcd_in = bcd;
    start  = 1'b1;
    tick();                                   // edge k
    start  = 1'b0;
    bcd_in = alt;
    check({tag, " busy@k"}, int'(busy), 1);
    check({tag, " done@k"}, int'(done), 0);
    tick();                                   // k+1
    tick();                                   // k+2
    tick();                                   // k+3
    check({tag, " busy@k+3"}, int'(busy), 1);
    check({tag, " hold@k+3"}, int'(bin_out), prev_bin);
    tick();                                   // k+4
    check({tag, " done@k+4"}, int'(done), 1);
    check({tag, " busy@k+4"}, int'(busy), 0);
    check({tag, " bin"}, int'(bin_out), exp_bin);
    check({tag, " err"}, int'(err), exp_err);
    tick();                                   // k+5
    check({tag, " done@k+5"}, int'(done), 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    done_count   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    tick();
    tick();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset bin", int'(bin_out), 0);
    check("reset err", int'(err), 0);
    rst = 1'b0;
    tick();

    // Basic conversion and the bounds.
    convert("h1234", 16'h1234, 16'h1234, 1234, 0, 0);
    convert("h9999", 16'h9999, 16'h9999, 9999, 0, 1234);
    convert("h0000", 16'h0000, 16'h0000, 0, 0, 9999);

    // Invalid digit.
`ifdef BCD2BIN_DIGIT_CHECK_EN
    convert("h00A5", 16'h00A5, 16'h00A5, 0, 1, 0);
`else
    convert("h00A5", 16'h00A5, 16'h00A5, 105, 0, 0);
`endif

    // Input change after the latch must not affect the result.
    convert("h0007 chg", 16'h0007, 16'h9999, 7, 0, 
`ifdef BCD2BIN_DIGIT_CHECK_EN
      0
`else
      105
`endif
    );

    // Start held high: one done at k+4, restart accepted at k+6, done at k+10.
    bcd_in = 16'h0012;
    start  = 1'b1;
    tick();                                   // edge k
    bcd_in = 16'h0034;
    done_count = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (done) done_count++;
    end
    tick();                                   // k+4
    check("hold start done@k+4", int'(done), 1);
    check("hold start bin1", int'(bin_out), 12);
    tick();                                   // k+5
    check("hold start done@k+5", int'(done), 0);
    check("hold start busy@k+5", int'(busy), 0);
    tick();                                   // k+6
    check("hold start busy@k+6", int'(busy), 1);
    start = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      tick();
      if (done) done_count++;
    end
    check("hold start no extra done", done_count, 0);
    tick();                                   // k+10
    check("hold start done@k+10", int'(done), 1);
    check("hold start bin2", int'(bin_out), 34);
    tick();

    // Reset mid-conversion: rst sampled at edge k+2.
    bcd_in = 16'h1234;
    start  = 1'b1;
    tick();                                   // k
    start  = 1'b0;
    tick();                                   // k+1
    rst = 1'b1;
    tick();                                   // k+2
    rst = 1'b0;
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst bin", int'(bin_out), 0);
    check("midrst err", int'(err), 0);
    done_count = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) done_count++;
    end
    check("midrst no done", done_count, 0);
    convert("h0042", 16'h0042, 16'h0042, 42, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
